// File: rtl/mem_access_stage.sv
// mem_access_stage: single-outstanding data-memory stage with load alignment/extension and writeback record.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [3:0]        ex_op,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [4:0]        ex_rd,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic              dmem_req_we,
   output logic [ADDR_W-1:0] dmem_req_addr,
   output logic [DATA_W-1:0] dmem_req_wdata,
   output logic [7:0]        dmem_req_be,
   input  logic              dmem_resp_valid,
   input  logic [DATA_W-1:0] dmem_resp_rdata,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_we,
   output logic              wb_exc
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
   state_t state, state_nx;
   logic              is_ld, is_st, misal;
   logic [1:0]        size, size_q;
   logic [2:0]        low_mask, off, off_q;
   logic [7:0]        be;
   logic              sgn_q, st_q, we_q, exc_q;
   logic [4:0]        rd_q;
   logic [DATA_W-1:0] data_q, raw, ld_data;
   always_comb begin
      is_ld    = ex_op inside {[4'd1:4'd7]};
      is_st    = ex_op inside {[4'd9:4'd12]};
      size     = ex_op == 4'd5 ? 2'd0 : ex_op == 4'd6 ? 2'd1 : ex_op == 4'd7 ? 2'd2 : ex_op[1:0] - 2'd1;
      low_mask = size == 2'd0 ? 3'd0 : size == 2'd1 ? 3'd1 : size == 2'd2 ? 3'd3 : 3'd7;
`ifdef MEM_MISALIGN_TRAP_EN
      misal    = (is_ld || is_st) && |(ex_addr[2:0] & low_mask);
      off      = ex_addr[2:0];
`else
      misal    = 1'b0;
      off      = ex_addr[2:0] & ~low_mask;
`endif
      be       = (size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0F : 8'hFF) << off;
   end
   always_comb begin
      raw     = dmem_resp_rdata >> {off_q, 3'b000};
      ld_data = size_q == 2'd0 ? {{56{sgn_q & raw[7]}}, raw[7:0]} :
                size_q == 2'd1 ? {{48{sgn_q & raw[15]}}, raw[15:0]} :
                size_q == 2'd2 ? {{32{sgn_q & raw[31]}}, raw[31:0]} : raw;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx       = state;
      ex_ready       = state == IDLE;
      dmem_req_valid = state == REQ;
      wb_valid       = state == OUT;
      unique case (state)
         IDLE: if (ex_valid) state_nx = (is_ld || is_st) && !misal ? REQ : OUT;
         REQ:  if (dmem_req_ready) state_nx = WAIT;
         WAIT: if (dmem_resp_valid) state_nx = OUT;
         OUT:  if (wb_ready) state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         size_q         <= '0;
         off_q          <= '0;
         sgn_q          <= 1'b0;
         st_q           <= 1'b0;
         we_q           <= 1'b0;
         exc_q          <= 1'b0;
         rd_q           <= '0;
         data_q         <= '0;
         dmem_req_we    <= 1'b0;
         dmem_req_addr  <= '0;
         dmem_req_wdata <= '0;
         dmem_req_be    <= '0;
      end else begin
         if (state == IDLE && ex_valid) begin
            size_q         <= size;
            off_q          <= off;
            sgn_q          <= ex_op inside {4'd1, 4'd2, 4'd3};
            st_q           <= is_st;
            rd_q           <= ex_rd;
            exc_q          <= misal;
            we_q           <= ex_rd != 5'd0 && !is_st && !misal;
            data_q         <= misal ? DATA_W'(ex_addr) : (is_ld || is_st) ? '0 : ex_result;
            dmem_req_we    <= is_st;
            dmem_req_addr  <= {ex_addr[ADDR_W-1:3], 3'b000};
            dmem_req_wdata <= ex_wdata << {off, 3'b000};
            dmem_req_be    <= be;
         end
         // stores complete with zero data; loads capture the extended lane
         if (state == WAIT && dmem_resp_valid) data_q <= st_q ? '0 : ld_data;
      end
   assign wb_rd   = rd_q;
   assign wb_data = data_q;
   assign wb_we   = we_q;
   assign wb_exc  = exc_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
   logic        clk = 1'b0, reset = 1'b0;
   logic        ex_valid = 1'b0, ex_ready;
   logic [3:0]  ex_op = '0;
   logic [63:0] ex_addr = '0, ex_wdata = '0, ex_result = '0;
   logic [4:0]  ex_rd = '0;
   logic        dmem_req_valid, dmem_req_ready = 1'b0, dmem_req_we;
   logic [63:0] dmem_req_addr, dmem_req_wdata;
   logic [7:0]  dmem_req_be;
   logic        dmem_resp_valid = 1'b0;
   logic [63:0] dmem_resp_rdata = '0;
   logic        wb_valid, wb_ready = 1'b0, wb_we, wb_exc;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   int n_cmp = 0, n_err = 0;
   always #5 clk = ~clk;
   mem_access_stage dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_result(ex_result), .ex_rd(ex_rd),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
      .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
      .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_we(wb_we), .wb_exc(wb_exc)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic issue(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] result, input logic [4:0] rd);
      ex_op = op; ex_addr = addr; ex_wdata = wdata; ex_result = result; ex_rd = rd; ex_valid = 1'b1;
      @(negedge clk);
      ex_valid = 1'b0;
   endtask
   task automatic run_mem(input logic [63:0] rdata);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0; dmem_resp_valid = 1'b1; dmem_resp_rdata = rdata;
      @(negedge clk);
      dmem_resp_valid = 1'b0;
   endtask
   task automatic drain();
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
   initial begin
      repeat (2) @(negedge clk);
      check("rst_ex_ready", 64'(ex_ready), 64'd1);
      check("rst_req_valid", 64'(dmem_req_valid), 64'd0);
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_wb_data", wb_data, 64'd0);
      check("rst_req_be", 64'(dmem_req_be), 64'd0);
      check("rst_wb_exc", 64'(wb_exc), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      issue(4'd4, 64'h1000, 64'd0, 64'd0, 5'd3);
      check("ld_req_valid", 64'(dmem_req_valid), 64'd1);
      check("ld_req_addr", dmem_req_addr, 64'h1000);
      check("ld_req_be", 64'(dmem_req_be), 64'hFF);
      check("ld_req_we", 64'(dmem_req_we), 64'd0);
      check("ld_ex_ready", 64'(ex_ready), 64'd0);
      run_mem(64'h8877665544332211);
      check("ld_wb_valid", 64'(wb_valid), 64'd1);
      check("ld_wb_data", wb_data, 64'h8877665544332211);
      check("ld_wb_we", 64'(wb_we), 64'd1);
      check("ld_wb_rd", 64'(wb_rd), 64'd3);
      drain();
      check("ld_idle", 64'(ex_ready), 64'd1);
      issue(4'd1, 64'h1003, 64'd0, 64'd0, 5'd7);
      check("lb_req_be", 64'(dmem_req_be), 64'h08);
      check("lb_req_addr", dmem_req_addr, 64'h1000);
      run_mem(64'h0000000080000000);
      check("lb_wb_data", wb_data, 64'hFFFFFFFFFFFFFF80);
      drain();
      issue(4'd5, 64'h1003, 64'd0, 64'd0, 5'd7);
      run_mem(64'h0000000080000000);
      check("lbu_wb_data", wb_data, 64'h80);
      drain();
      issue(4'd2, 64'h1006, 64'd0, 64'd0, 5'd8);
      check("lh_req_be", 64'(dmem_req_be), 64'hC0);
      run_mem(64'hBEEF000000000000);
      check("lh_wb_data", wb_data, 64'hFFFFFFFFFFFFBEEF);
      drain();
      issue(4'd7, 64'h1004, 64'd0, 64'd0, 5'd8);
      check("lwu_req_be", 64'(dmem_req_be), 64'hF0);
      run_mem(64'h80000000_00000000);
      check("lwu_wb_data", wb_data, 64'h80000000);
      drain();
      issue(4'd10, 64'h2006, 64'hABCD, 64'd0, 5'd9);
      check("sh_req_be", 64'(dmem_req_be), 64'hC0);
      check("sh_req_wdata", dmem_req_wdata, 64'hABCD000000000000);
      check("sh_req_we", 64'(dmem_req_we), 64'd1);
      check("sh_req_addr", dmem_req_addr, 64'h2000);
      run_mem(64'hFFFFFFFFFFFFFFFF);
      check("sh_wb_valid", 64'(wb_valid), 64'd1);
      check("sh_wb_we", 64'(wb_we), 64'd0);
      check("sh_wb_data", wb_data, 64'd0);
      drain();
      issue(4'd0, 64'd0, 64'd0, 64'h55, 5'd5);
      check("none_wb_valid", 64'(wb_valid), 64'd1);
      check("none_wb_data", wb_data, 64'h55);
      check("none_wb_we", 64'(wb_we), 64'd1);
      check("none_wb_rd", 64'(wb_rd), 64'd5);
      check("none_no_req", 64'(dmem_req_valid), 64'd0);
      repeat (2) begin
         @(negedge clk);
         check("none_hold_valid", 64'(wb_valid), 64'd1);
         check("none_hold_data", wb_data, 64'h55);
         check("none_hold_ex_ready", 64'(ex_ready), 64'd0);
      end
      drain();
      check("none_drained", 64'(wb_valid), 64'd0);
      issue(4'd0, 64'd0, 64'd0, 64'h55, 5'd0);
      check("rd0_wb_we", 64'(wb_we), 64'd0);
      check("rd0_wb_data", wb_data, 64'h55);
      drain();
      issue(4'd15, 64'h3000, 64'd0, 64'h1234, 5'd2);
      check("badop_no_req", 64'(dmem_req_valid), 64'd0);
      check("badop_wb_data", wb_data, 64'h1234);
      drain();
      issue(4'd3, 64'h1000, 64'd0, 64'd0, 5'd4);
      repeat (3) begin
         check("stall_req_valid", 64'(dmem_req_valid), 64'd1);
         check("stall_req_addr", dmem_req_addr, 64'h1000);
         check("stall_req_be", 64'(dmem_req_be), 64'h0F);
         check("stall_ex_ready", 64'(ex_ready), 64'd0);
         @(negedge clk);
      end
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      check("wait_req_valid", 64'(dmem_req_valid), 64'd0);
      check("wait_ex_ready", 64'(ex_ready), 64'd0);
      reset = 1'b0;
      #1;
      check("mid_rst_ex_ready", 64'(ex_ready), 64'd1);
      check("mid_rst_req_addr", dmem_req_addr, 64'd0);
      check("mid_rst_req_be", 64'(dmem_req_be), 64'd0);
      check("mid_rst_wb_valid", 64'(wb_valid), 64'd0);
      @(negedge clk);
      reset = 1'b1; dmem_resp_valid = 1'b1; dmem_resp_rdata = 64'hDEAD;
      @(negedge clk);
      dmem_resp_valid = 1'b0;
      check("late_resp_wb_valid", 64'(wb_valid), 64'd0);
      check("late_resp_ex_ready", 64'(ex_ready), 64'd1);
`ifdef MEM_MISALIGN_TRAP_EN
      issue(4'd3, 64'h1002, 64'd0, 64'd0, 5'd6);
      check("trap_no_req", 64'(dmem_req_valid), 64'd0);
      check("trap_wb_valid", 64'(wb_valid), 64'd1);
      check("trap_wb_exc", 64'(wb_exc), 64'd1);
      check("trap_wb_data", wb_data, 64'h1002);
      check("trap_wb_we", 64'(wb_we), 64'd0);
      drain();
      issue(4'd9, 64'h1003, 64'h77, 64'd0, 5'd0);
      check("sb_no_trap_req", 64'(dmem_req_valid), 64'd1);
      run_mem(64'd0);
      check("sb_no_trap_exc", 64'(wb_exc), 64'd0);
      drain();
`else
      issue(4'd3, 64'h1002, 64'd0, 64'd0, 5'd6);
      check("mis_req_valid", 64'(dmem_req_valid), 64'd1);
      check("mis_req_addr", dmem_req_addr, 64'h1000);
      check("mis_req_be", 64'(dmem_req_be), 64'h0F);
      run_mem(64'h1234567880000001);
      check("mis_wb_data", wb_data, 64'hFFFFFFFF80000001);
      check("mis_wb_exc", 64'(wb_exc), 64'd0);
      drain();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
